serial_frame_tx: RTL and testbench

//   Transmit end of a UART-style serial link: accepts one parallel word over a

---
 rtl/serial_frame_tx.sv | 113 +++++++++++
 tb/tb_serial_frame_tx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial UART-style transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// o_txd is registered and drops on the accepting edge; o_ready is high only while idle.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_txd,
  output logic              o_busy,
  output logic              o_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shift;
  logic [DATA_W-1:0]   shift_nxt;
  logic                par;
  logic                txd;
  logic                accept;
  logic                bit_end;

  assign accept    = i_valid && (state == IDLE);
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign shift_nxt = shift >> 1;
  assign o_txd     = txd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = START;
      START:  if (bit_end) state_nxt = DATA;
      DATA:   if (bit_end && bit_cnt == DATA_LAST)
                state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP:   if (bit_end && bit_cnt == STOP_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_ready = (state == IDLE);
    o_busy  = (state != IDLE);
    o_done  = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  end

  // txd is loaded with the value of the bit about to start, so the line is a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      if (accept) begin
        shift <= i_data;
        par   <= (^i_data) ^ (PARITY_ODD != 0);
        txd   <= 1'b0;
      end
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      case (state)
        START: txd <= shift[0];
        DATA: begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= '0;
            txd     <= (PARITY_EN != 0) ? par : 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= shift_nxt;
            txd     <= shift_nxt[0];
          end
        end
        PARITY: txd <= 1'b1;
        STOP: begin
          txd <= 1'b1;
          if (bit_cnt == STOP_LAST) bit_cnt <= '0;
          else                      bit_cnt <= bit_cnt + 1'b1;
        end
        default: txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx across five parameter sets; expected line bits queued per frame.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld  [5];
  logic [7:0] dat  [5];
  logic       txd  [5];
  logic       rdy  [5];
  logic       busy [5];
  logic       done [5];

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .i_valid(vld[0]), .o_ready(rdy[0]), .i_data(dat[0]),
    .o_txd(txd[0]), .o_busy(busy[0]), .o_done(done[0]));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .i_valid(vld[1]), .o_ready(rdy[1]), .i_data(dat[1]),
    .o_txd(txd[1]), .o_busy(busy[1]), .o_done(done[1]));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .i_valid(vld[2]), .o_ready(rdy[2]), .i_data(dat[2]),
    .o_txd(txd[2]), .o_busy(busy[2]), .o_done(done[2]));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .i_valid(vld[3]), .o_ready(rdy[3]), .i_data(dat[3]),
    .o_txd(txd[3]), .o_busy(busy[3]), .o_done(done[3]));
  serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_tiny (
    .clk(clk), .rst_n(rst_n), .i_valid(vld[4]), .o_ready(rdy[4]), .i_data(dat[4][0:0]),
    .o_txd(txd[4]), .o_busy(busy[4]), .o_done(done[4]));

  function automatic int cfg_dw(input int i);  return (i == 4) ? 1 : 8;          endfunction
  function automatic int cfg_clk(input int i); return (i == 4) ? 2 : 16;         endfunction
  function automatic int cfg_pe(input int i);  return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int cfg_po(input int i);  return (i == 2) ? 1 : 0;          endfunction
  function automatic int cfg_sb(input int i);  return (i == 3) ? 2 : 1;          endfunction

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h at %0t", tag, idx, obs, exp, $time);
    end
  endtask

  // Offers word at an idle cycle, then checks every clk of the frame against the queued bit sequence.
  // With hold set, i_valid stays high and i_data switches to mid halfway through the frame.
  task automatic run_frame(input int idx, input logic [7:0] word, input logic hold, input logic [7:0] mid);
    int   c, total;
    logic p, b;
    c     = cfg_clk(idx);
    total = (1 + cfg_dw(idx) + cfg_pe(idx) + cfg_sb(idx)) * c;
    b     = 1'b1;
    @(negedge clk);
    chk("idle_ready", idx, {7'd0, rdy[idx]}, 8'd1);
    chk("idle_txd",   idx, {7'd0, txd[idx]}, 8'd1);
    chk("idle_busy",  idx, {7'd0, busy[idx]}, 8'd0);
    vld[idx] = 1'b1;
    dat[idx] = word;
    exp_q.push_back(1'b0);
    p = (cfg_po(idx) != 0);
    for (int i = 0; i < cfg_dw(idx); i++) begin
      exp_q.push_back(word[i]);
      p = p ^ word[i];
    end
    if (cfg_pe(idx) != 0) exp_q.push_back(p);
    for (int i = 0; i < cfg_sb(idx); i++) exp_q.push_back(1'b1);
    for (int cyc = 0; cyc < total; cyc++) begin
      @(negedge clk);
      if (cyc == 0 && !hold) vld[idx] = 1'b0;
      if (cyc == total / 2)  dat[idx] = mid;
      if (cyc % c == 0)      b = exp_q.pop_front();
      chk("txd",   idx, {7'd0, txd[idx]},  {7'd0, b});
      chk("done",  idx, {7'd0, done[idx]}, {7'd0, (cyc == total - 1)});
      chk("busy",  idx, {7'd0, busy[idx]}, 8'd1);
      chk("ready", idx, {7'd0, rdy[idx]},  8'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_txd",   0, {7'd0, txd[0]},  8'd1);
    chk("rst_ready", 0, {7'd0, rdy[0]},  8'd1);
    chk("rst_busy",  0, {7'd0, busy[0]}, 8'd0);
    chk("rst_done",  0, {7'd0, done[0]}, 8'd0);
    rst_n = 1'b1;

    run_frame(0, 8'hA5, 1'b0, 8'h00);
    run_frame(1, 8'h07, 1'b0, 8'h00);
    run_frame(2, 8'h07, 1'b0, 8'h00);
    run_frame(3, 8'h00, 1'b1, 8'hFF);
    run_frame(3, 8'hFF, 1'b0, 8'h00);
    run_frame(0, 8'h5A, 1'b1, 8'hC3);
    run_frame(0, 8'hC3, 1'b0, 8'h00);

    // Abort a frame of zeros during data bit 3 and check the asynchronous return to idle.
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (69) @(negedge clk);
    chk("pre_rst_txd",  0, {7'd0, txd[0]},  8'd0);
    chk("pre_rst_busy", 0, {7'd0, busy[0]}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_txd",   0, {7'd0, txd[0]},  8'd1);
    chk("arst_busy",  0, {7'd0, busy[0]}, 8'd0);
    chk("arst_ready", 0, {7'd0, rdy[0]},  8'd1);
    chk("arst_done",  0, {7'd0, done[0]}, 8'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_done", 0, {7'd0, done[0]}, 8'd0);
    end
    rst_n = 1'b1;
    run_frame(0, 8'h3C, 1'b0, 8'h00);

    run_frame(4, 8'h01, 1'b0, 8'h00);
    @(negedge clk);
    chk("tiny_end_txd",  4, {7'd0, txd[4]},  8'd1);
    chk("tiny_end_busy", 4, {7'd0, busy[4]}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
